uart_config_responder: RTL and testbench

Responder side of the UART link-configuration handshake. Snoops the received byte stream for a run of SYN bytes sent by the remote initiator, requests permission from the host, acknowledges, then accepts configuration packets (data width, parity mode, stop bits, end), acknowledging each one. On the END packet it commits the new 6-bit configuration to the UART datapath. It sits between the receiver/RX FIFO, the TX FIFO/transmitter and the host interrupt logic.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_timeout_counter.sv | 36 +++
 rtl/uart_config_responder.sv | 158 +++++++++++++++
 tb/tb_uart_config_responder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART link-configuration constants, config layout and packet helpers.
// Used by both sides of the configuration handshake (responder and initiator).
// Contents:
//   SYN_CHAR / ACKN_CHAR   handshake bytes
//   ID_*                   configuration packet identifiers
//   CLK_HZ / TIMEOUT_10MS  system clock and 10 ms handshake wait limit
//   uart_cfg_t             6-bit active configuration {width, parity, stop}
//   assemble_packet / packet_id / packet_option  packet build and field extract
package uart_pkg;

    localparam logic [7:0] SYN_CHAR  = 8'h16;
    localparam logic [7:0] ACKN_CHAR = 8'hFF;

    localparam logic [1:0] ID_END    = 2'b00;
    localparam logic [1:0] ID_WIDTH  = 2'b01;
    localparam logic [1:0] ID_PARITY = 2'b10;
    localparam logic [1:0] ID_STOP   = 2'b11;

    localparam int CLK_HZ       = 50_000_000;
    localparam int TIMEOUT_10MS = CLK_HZ / 100;

    localparam int CFG_W = 6;

    // Field order fixes the config_o bit layout: [5:4] width, [3:2] parity, [1:0] stop.
    typedef struct packed {
        logic [1:0] width;
        logic [1:0] parity;
        logic [1:0] stop;
    } uart_cfg_t;

    function automatic logic [7:0] assemble_packet(input logic [1:0] id, input logic [1:0] option);
        return {4'b0000, option, id};
    endfunction

    function automatic logic [1:0] packet_id(input logic [7:0] pkt);
        return pkt[1:0];
    endfunction

    function automatic logic [1:0] packet_option(input logic [7:0] pkt);
        return pkt[3:2];
    endfunction

endpackage

// File: rtl/uart_timeout_counter.sv
// uart_timeout_counter: cycle counter that flags expiry after LIMIT counted cycles.
// Ports:
//   clk_i    in   system clock
//   rst_n_i  in   asynchronous active-low reset
//   clear    in   synchronous clear to 0 (takes priority over enable)
//   enable   in   count one per cycle while high
//   expired  out  high while enabled and the count equals LIMIT
module uart_timeout_counter
    import uart_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_10MS
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + W'(1);
    end

    // Saturates at LIMIT so a caller that ignores expiry never sees a wrap.
    assign expired = enable && (count == W'(LIMIT));

endmodule

// File: rtl/uart_config_responder.sv
// uart_config_responder: responder side of the UART link-configuration handshake.
// Detects a run of SYN bytes, asks the host for permission, acknowledges, then
// accepts width/parity/stop/END packets (each acknowledged) and commits the new
// configuration on END.
// Ports:
//   clk_i, rst_n_i              clock, asynchronous active-low reset
//   rx_valid_i, rx_data_i       receiver byte strobe / byte (RX FIFO head outside IDLE)
//   rx_fifo_empty_i             RX FIFO empty
//   rx_fifo_read_o              RX FIFO pop
//   tx_fifo_full_i              TX FIFO full
//   tx_fifo_write_o, tx_data_o  TX FIFO push / byte
//   tx_done_i                   transmitter finished a frame
//   enable_config_receive_i     host allows remote configuration
//   request_ack_i               host accepts the pending request
//   config_req_slv_o            request pending (interrupt source)
//   config_o                    active config {width, parity, stop}
//   config_valid_o              config_o updated strobe
//   config_error_o              handshake timeout strobe
//   busy_o                      handshake in progress
module uart_config_responder
    import uart_pkg::*;
#(
    parameter int         SYN_NUMBER     = 3,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_10MS,
    parameter logic [7:0] SYN            = SYN_CHAR,
    parameter logic [7:0] ACKN           = ACKN_CHAR
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             rx_valid_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_fifo_empty_i,
    output logic             rx_fifo_read_o,
    input  logic             tx_fifo_full_i,
    output logic             tx_fifo_write_o,
    output logic [7:0]       tx_data_o,
    input  logic             tx_done_i,
    input  logic             enable_config_receive_i,
    input  logic             request_ack_i,
    output logic             config_req_slv_o,
    output logic [CFG_W-1:0] config_o,
    output logic             config_valid_o,
    output logic             config_error_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SEND_ACK,
        WAIT_TX,
        WAIT_PKT,
        DONE
    } state_t;

    localparam int SCW = $clog2(SYN_NUMBER + 1);

    state_t         state;
    logic [SCW-1:0] syn_cnt;
    uart_cfg_t      active;
    uart_cfg_t      shadow;
    logic           end_seen;
    logic           timing;
    logic           timed_out;
    logic           push;
    logic           pop;

    // Only REQ and WAIT_PKT are time-limited; every other state holds the counter
    // cleared, so it always starts from 0 on entry to either of them.
    assign timing = (state == REQ) || (state == WAIT_PKT);

    uart_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear   (!timing),
        .enable  (timing),
        .expired (timed_out)
    );

    assign push = (state == SEND_ACK) && !tx_fifo_full_i;
    assign pop  = (state == WAIT_PKT) && !rx_fifo_empty_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            syn_cnt  <= '0;
            active   <= '0;
            shadow   <= '0;
            end_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!enable_config_receive_i)
                        syn_cnt <= '0;
                    else if (rx_valid_i) begin
                        if (rx_data_i != SYN)
                            syn_cnt <= '0;
                        else if (syn_cnt == SCW'(SYN_NUMBER - 1)) begin
                            syn_cnt <= '0;
                            shadow  <= active;
                            state   <= REQ;
                        end else
                            syn_cnt <= syn_cnt + SCW'(1);
                    end
                end
                // An ack arriving in the timeout cycle still wins.
                REQ: begin
                    if (request_ack_i)
                        state <= SEND_ACK;
                    else if (timed_out)
                        state <= IDLE;
                end
                SEND_ACK: begin
                    if (push)
                        state <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done_i)
                        state <= end_seen ? DONE : WAIT_PKT;
                end
                WAIT_PKT: begin
                    if (pop) begin
                        case (packet_id(rx_data_i))
                            ID_WIDTH:  shadow.width  <= packet_option(rx_data_i);
                            ID_PARITY: shadow.parity <= packet_option(rx_data_i);
                            ID_STOP:   shadow.stop   <= packet_option(rx_data_i);
                            ID_END:    end_seen      <= 1'b1;
                        endcase
                        state <= SEND_ACK;
                    end else if (timed_out) begin
                        // Shadow is simply abandoned; it is reloaded from active on the next request.
                        end_seen <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DONE: begin
                    active   <= shadow;
                    end_seen <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign config_o         = active;
    assign busy_o           = state != IDLE;
    assign config_req_slv_o = state == REQ;
    assign tx_fifo_write_o  = push;
    assign tx_data_o        = (state == SEND_ACK) ? ACKN : 8'h00;
    assign rx_fifo_read_o   = pop;
    assign config_valid_o   = state == DONE;
    assign config_error_o   = timed_out && (((state == REQ) && !request_ack_i) ||
                                            ((state == WAIT_PKT) && rx_fifo_empty_i));

endmodule

// File: tb/tb_uart_config_responder.sv
// tb_uart_config_responder: directed self-checking bench for uart_config_responder.
module tb_uart_config_responder;

    localparam int         TMO  = 20;
    localparam logic [7:0] SYNB = 8'h16;
    localparam logic [7:0] ACKB = 8'hFF;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_fifo_empty;
    logic       rx_fifo_read;
    logic       tx_fifo_full;
    logic       tx_fifo_write;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       enable;
    logic       request_ack;
    logic       config_req;
    logic [5:0] config_val;
    logic       config_valid;
    logic       config_error;
    logic       busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int err_pulses = 0;
    int valid_pulses = 0;
    int e0;

    logic [7:0] exp_tx[$];
    logic [5:0] exp_cfg[$];
    logic [5:0] mon_cfg;

    uart_config_responder #(
        .SYN_NUMBER     (3),
        .TIMEOUT_CYCLES (TMO),
        .SYN            (SYNB),
        .ACKN           (ACKB)
    ) dut (
        .clk_i                   (clk),
        .rst_n_i                 (rst_n),
        .rx_valid_i              (rx_valid),
        .rx_data_i               (rx_data),
        .rx_fifo_empty_i         (rx_fifo_empty),
        .rx_fifo_read_o          (rx_fifo_read),
        .tx_fifo_full_i          (tx_fifo_full),
        .tx_fifo_write_o         (tx_fifo_write),
        .tx_data_o               (tx_data),
        .tx_done_i               (tx_done),
        .enable_config_receive_i (enable),
        .request_ack_i           (request_ack),
        .config_req_slv_o        (config_req),
        .config_o                (config_val),
        .config_valid_o          (config_valid),
        .config_error_o          (config_error),
        .busy_o                  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic syn(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic start_req();
        syn(SYNB);
        syn(SYNB);
        syn(SYNB);
    endtask

    // From REQ: ack, see the ACKN push, finish the frame, land in WAIT_PKT.
    task automatic ack_to_pkt();
        request_ack = 1'b1;
        exp_tx.push_back(ACKB);
        tick(1);
        request_ack = 1'b0;
        check("ack_push", 32'(tx_fifo_write), 1);
        tick(1);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
    endtask

    // From WAIT_PKT: present one FIFO byte, see it popped and acknowledged.
    task automatic pkt(input logic [7:0] b);
        rx_data       = b;
        rx_fifo_empty = 1'b0;
        #1;
        check("pkt_pop", 32'(rx_fifo_read), 1);
        exp_tx.push_back(ACKB);
        tick(1);
        rx_fifo_empty = 1'b1;
        rx_data       = 8'h00;
        check("pkt_single_pop", 32'(rx_fifo_read), 0);
        tick(1);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_req"}, 32'(config_req), 0);
        check({tag, "_write"}, 32'(tx_fifo_write), 0);
        check({tag, "_read"}, 32'(rx_fifo_read), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_valid"}, 32'(config_valid), 0);
        check({tag, "_error"}, 32'(config_error), 0);
        check({tag, "_config"}, 32'(config_val), 0);
    endtask

    // Scoreboard side: every push and every commit is matched against the queues.
    always @(negedge clk) begin
        if (config_error)
            err_pulses++;
        if (tx_fifo_write) begin
            if (exp_tx.size() == 0)
                check("tx_unexpected", 32'(tx_fifo_write), 0);
            else
                check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        if (config_valid) begin
            valid_pulses++;
            if (exp_cfg.size() == 0)
                check("cfg_unexpected", 32'(config_valid), 0);
            else begin
                mon_cfg = exp_cfg.pop_front();
                @(posedge clk);
                #1;
                check("config_commit", 32'(config_val), 32'(mon_cfg));
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        rx_valid      = 1'b0;
        rx_data       = 8'h00;
        rx_fifo_empty = 1'b1;
        tx_fifo_full  = 1'b0;
        tx_done       = 1'b0;
        enable        = 1'b1;
        request_ack   = 1'b0;
        tick(2);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick(1);

        // Broken SYN run, then a request that times out in REQ.
        syn(SYNB);
        syn(SYNB);
        syn(8'h41);
        syn(SYNB);
        syn(SYNB);
        check("broken_run_no_req", 32'(config_req), 0);
        syn(SYNB);
        check("req_after_third_syn", 32'(config_req), 1);
        check("busy_in_req", 32'(busy), 1);
        e0 = err_pulses;
        tick(TMO - 1);
        check("req_no_err_before_limit", 32'(config_error), 0);
        tick(1);
        check("req_err_at_limit", 32'(config_error), 1);
        tick(1);
        check("req_timeout_idle", 32'(busy), 0);
        check("req_timeout_one_pulse", 32'(err_pulses), 32'(e0 + 1));
        check("req_timeout_config", 32'(config_val), 0);

        // SYNs while disabled must not count.
        enable = 1'b0;
        start_req();
        check("disabled_idle", 32'(busy), 0);
        enable = 1'b1;
        syn(SYNB);
        syn(SYNB);
        check("disabled_cnt_held", 32'(config_req), 0);
        syn(SYNB);
        check("enabled_req", 32'(config_req), 1);

        // Timeout in WAIT_PKT after a width packet: nothing committed.
        ack_to_pkt();
        pkt(8'h0D);
        e0 = err_pulses;
        tick(TMO);
        check("pkt_err_at_limit", 32'(config_error), 1);
        tick(1);
        check("pkt_timeout_idle", 32'(busy), 0);
        check("pkt_timeout_one_pulse", 32'(err_pulses), 32'(e0 + 1));
        check("pkt_timeout_config", 32'(config_val), 0);

        // Happy path: width=11, parity=01, stop=00, END -> {11,01,00}.
        start_req();
        ack_to_pkt();
        pkt(8'h0D);
        pkt(8'h06);
        pkt(8'h03);
        pkt(8'h00);
        check("happy_valid", 32'(config_valid), 1);
        check("happy_config_held_in_done", 32'(config_val), 0);
        exp_cfg.push_back(6'b110100);
        tick(1);
        check("happy_config", 32'(config_val), 32'(6'b110100));
        check("happy_idle", 32'(busy), 0);

        // Ack in the timeout cycle wins; then TX backpressure and a parity-only update.
        e0 = err_pulses;
        start_req();
        tick(TMO);
        request_ack  = 1'b1;
        tx_fifo_full = 1'b1;
        #1;
        check("ack_beats_timeout", 32'(config_error), 0);
        exp_tx.push_back(ACKB);
        tick(1);
        request_ack = 1'b0;
        repeat (5) begin
            check("backpressure_no_push", 32'(tx_fifo_write), 0);
            tick(1);
        end
        tx_fifo_full = 1'b0;
        #1;
        check("backpressure_push", 32'(tx_fifo_write), 1);
        tick(1);
        tick(TMO + 5);
        check("wait_tx_still_busy", 32'(busy), 1);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        pkt(8'h0A);
        pkt(8'h00);
        check("partial_valid", 32'(config_valid), 1);
        exp_cfg.push_back(6'b111000);
        tick(1);
        check("partial_config", 32'(config_val), 32'(6'b111000));
        check("backpressure_no_error", 32'(err_pulses), 32'(e0));

        // Lone END commits the unchanged configuration.
        start_req();
        ack_to_pkt();
        pkt(8'h00);
        check("lone_end_valid", 32'(config_valid), 1);
        exp_cfg.push_back(6'b111000);
        tick(1);
        check("lone_end_config", 32'(config_val), 32'(6'b111000));

        // Asynchronous reset in WAIT_PKT.
        start_req();
        ack_to_pkt();
        check("pre_reset_busy", 32'(busy), 1);
        rx_fifo_empty = 1'b0;
        rx_data       = 8'h0D;
        #1;
        check("pre_reset_read", 32'(rx_fifo_read), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        rx_fifo_empty = 1'b1;
        rx_data       = 8'h00;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        check("tx_queue_drained", 32'(exp_tx.size()), 0);
        check("cfg_queue_drained", 32'(exp_cfg.size()), 0);
        check("valid_pulse_total", 32'(valid_pulses), 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
